instruction_fetch_stage: RTL and testbench

Pipeline front end that produces the instruction stream consumed by the decode/Control unit. It holds the program counter, addresses the instruction memory, and registers each fetched word and its PC+4 into the IF/ID pipeline register for decode. It accepts stall, flush and branch/jump redirect requests from the hazard and execute stages.

---
 rtl/instruction_fetch_stage_pkg.sv | 30 +++
 rtl/instruction_fetch_stage_if.sv | 29 ++
 rtl/instruction_fetch_stage_if_id_register.sv | 27 ++
 rtl/instruction_fetch_stage.sv | 72 +++++++
 tb/tb_instruction_fetch_stage.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch/decode definitions: widths, bubble word, reset PC default and the IF/ID payload.
// Reused by decode, Control and the hazard unit so the bubble encoding stays in one place.
package instruction_fetch_stage_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [PC_W-1:0]    RESET_PC_DEF = 32'h0000_0000;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        pc_t    pc_plus4;
        logic   valid;
    } ifid_t;

    typedef enum logic [1:0] {
        PC_SEL_SEQ      = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

    function automatic pc_t word_align(input pc_t addr);
        return addr & ~pc_t'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bundle: hazard/execute control in, instruction memory port, IF/ID out.
// master = fetch stage, slave = the surrounding pipeline and instruction memory.
interface instruction_fetch_stage_if #(
    parameter int IMEM_ADDR_W = 10
);
    import instruction_fetch_stage_pkg::*;

    logic                   Stall;
    logic                   Flush;
    logic                   BranchTaken;
    pc_t                    BranchTarget;
    instr_t                 IMemData;
    logic [IMEM_ADDR_W-1:0] IMemAddr;
    pc_t                    PC;
    instr_t                 IFID_Instruction;
    pc_t                    IFID_PCPlus4;
    logic                   IFID_Valid;

    modport master (
        input  Stall, Flush, BranchTaken, BranchTarget, IMemData,
        output IMemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid
    );

    modport slave (
        output Stall, Flush, BranchTaken, BranchTarget, IMemData,
        input  IMemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid
    );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: captures fetched word, its PC+4 and a valid flag.
// Latency 1 cycle; clear (bubble) overrides hold, hold freezes the contents indefinitely.
// No backpressure of its own: hold is driven by the hazard unit's stall.
module if_id_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter instr_t NOP_WORD = NOP_WORD_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  clear,
    input  ifid_t d,
    output ifid_t q
);

    localparam ifid_t BUBBLE = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, next-PC select, instruction memory addressing, IF/ID register.
// Latency: word at PC reaches IF/ID one edge later; redirect costs one bubble cycle.
// Stall holds PC and IF/ID for as long as it is high; redirect overrides stall.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter pc_t    RESET_PC    = RESET_PC_DEF,
    parameter int     IMEM_ADDR_W = 10,
    parameter instr_t NOP_WORD    = NOP_WORD_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    instruction_fetch_stage_if.master  bus
);

    pc_t     pc_q;
    pc_t     pc_plus4;
    pc_t     pc_nxt;
    pc_sel_e pc_sel;
    ifid_t   ifid_d;
    ifid_t   ifid_q;

    assign pc_plus4 = pc_q + pc_t'(4);

    always_comb begin
        pc_sel = PC_SEL_SEQ;
        if (bus.BranchTaken) begin
            pc_sel = PC_SEL_REDIRECT;
        end else if (bus.Stall) begin
            pc_sel = PC_SEL_HOLD;
        end
    end

    always_comb begin
        pc_nxt = pc_plus4;
        case (pc_sel)
            PC_SEL_REDIRECT: pc_nxt = word_align(bus.BranchTarget);
            PC_SEL_HOLD:     pc_nxt = pc_q;
            default:         pc_nxt = pc_plus4;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_nxt;
        end
    end

    // The word being fetched now is dropped on a redirect; flush bubbles even while stalled.
    assign ifid_d = '{instr: bus.IMemData, pc_plus4: pc_plus4, valid: 1'b1};

    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_register (
        .clk   (Clk),
        .reset (Reset),
        .hold  (bus.Stall),
        .clear (bus.BranchTaken | bus.Flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    // Addresses past the memory depth simply wrap; there is no range check.
    assign bus.IMemAddr         = pc_q[IMEM_ADDR_W+1:2];
    assign bus.PC               = pc_q;
    assign bus.IFID_Instruction = ifid_q.instr;
    assign bus.IFID_PCPlus4     = ifid_q.pc_plus4;
    assign bus.IFID_Valid       = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized check of instruction_fetch_stage against a cycle-level behavioural model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    instruction_fetch_stage_if #(.IMEM_ADDR_W(10)) bus_a ();
    instruction_fetch_stage_if #(.IMEM_ADDR_W(10)) bus_b ();

    logic [31:0] imem [0:1023];

    assign bus_a.IMemData = imem[bus_a.IMemAddr];
    assign bus_b.IMemData = imem[bus_b.IMemAddr];

    instruction_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_ADDR_W (10),
        .NOP_WORD    (NOP)
    ) dut_a (
        .Clk   (clk),
        .Reset (rst_a),
        .bus   (bus_a)
    );

    instruction_fetch_stage #(
        .RESET_PC    (32'hFFFF_FFF8),
        .IMEM_ADDR_W (10),
        .NOP_WORD    (NOP)
    ) dut_b (
        .Clk   (clk),
        .Reset (rst_b),
        .bus   (bus_b)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference state: what the pipeline front end should show after each edge.
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_p4;
    logic        m_v;

    task automatic bubble();
        m_ins = NOP;
        m_p4  = 32'h0;
        m_v   = 1'b0;
    endtask

    task automatic step(input logic r, input logic st, input logic fl,
                        input logic bt, input logic [31:0] tg);
        logic [31:0] fetched;
        rst_a              = r;
        bus_a.Stall        = st;
        bus_a.Flush        = fl;
        bus_a.BranchTaken  = bt;
        bus_a.BranchTarget = tg;
        fetched = imem[m_pc[11:2]];
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0;
            bubble();
        end else if (bt) begin
            m_pc = {tg[31:2], 2'b00};
            bubble();
        end else if (st) begin
            if (fl) bubble();
        end else if (fl) begin
            m_pc = m_pc + 32'd4;
            bubble();
        end else begin
            m_ins = fetched;
            m_p4  = m_pc + 32'd4;
            m_v   = 1'b1;
            m_pc  = m_pc + 32'd4;
        end
        #1;
        check("pc",    bus_a.PC, m_pc);
        check("iaddr", 32'(bus_a.IMemAddr), {22'h0, m_pc[11:2]});
        check("instr", bus_a.IFID_Instruction, m_ins);
        check("pcp4",  bus_a.IFID_PCPlus4, m_p4);
        check("valid", 32'(bus_a.IFID_Valid), {31'h0, m_v});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        imem[0] = 32'h2008_0005;
        imem[1] = 32'h2009_0007;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.Stall = 1'b0; bus_a.Flush = 1'b0; bus_a.BranchTaken = 1'b0; bus_a.BranchTarget = '0;
        bus_b.Stall = 1'b0; bus_b.Flush = 1'b0; bus_b.BranchTaken = 1'b0; bus_b.BranchTarget = '0;
        m_pc = 32'h0;
        bubble();

        // Wrap-around instance: PC FFFF_FFF8 -> FFFF_FFFC -> 0000_0000.
        @(posedge clk); #1;
        check("b_rst_pc",    bus_b.PC, 32'hFFFF_FFF8);
        check("b_rst_valid", 32'(bus_b.IFID_Valid), 32'h0);
        rst_b = 1'b0;
        @(posedge clk); #1;
        check("b_pc1",    bus_b.PC, 32'hFFFF_FFFC);
        check("b_instr1", bus_b.IFID_Instruction, imem[1022]);
        check("b_pcp4_1", bus_b.IFID_PCPlus4, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("b_pc2",    bus_b.PC, 32'h0000_0000);
        check("b_instr2", bus_b.IFID_Instruction, imem[1023]);
        check("b_pcp4_2", bus_b.IFID_PCPlus4, 32'h0000_0000);
        check("b_valid2", 32'(bus_b.IFID_Valid), 32'h1);

        // Directed sequence on the RESET_PC=0 instance.
        step(1, 0, 0, 0, 0);
        check("rst_instr", bus_a.IFID_Instruction, NOP);
        step(0, 0, 0, 0, 0);
        check("first_word", bus_a.IFID_Instruction, 32'h2008_0005);
        check("first_p4",   bus_a.IFID_PCPlus4, 32'd4);
        step(0, 0, 0, 0, 0);
        check("second_word", bus_a.IFID_Instruction, 32'h2009_0007);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            check("stall_pc",   bus_a.PC, 32'd8);
            check("stall_word", bus_a.IFID_Instruction, 32'h2009_0007);
        end
        step(0, 0, 0, 0, 0);
        check("resume_p4", bus_a.IFID_PCPlus4, 32'd12);
        step(0, 0, 0, 1, 32'h0000_0043);
        check("redir_pc",    bus_a.PC, 32'h40);
        check("redir_valid", 32'(bus_a.IFID_Valid), 32'h0);
        step(0, 0, 0, 0, 0);
        check("target_word", bus_a.IFID_Instruction, imem[16]);
        check("target_p4",   bus_a.IFID_PCPlus4, 32'h44);
        step(0, 1, 0, 1, 32'h0000_0100);
        check("bt_stall_pc", bus_a.PC, 32'h100);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("st_fl_pc",    bus_a.PC, 32'h104);
        check("st_fl_valid", 32'(bus_a.IFID_Valid), 32'h0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 32'h20);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("rst_stall_pc",    bus_a.PC, 32'h0);
        check("rst_stall_instr", bus_a.IFID_Instruction, NOP);

        // Random mix of stall, flush, redirect and occasional reset.
        for (int n = 0; n < 600; n++) begin
            logic r, st, fl, bt;
            logic [31:0] tg;
            r  = ($urandom_range(99) < 2);
            st = ($urandom_range(99) < 25);
            fl = ($urandom_range(99) < 12);
            bt = ($urandom_range(99) < 10);
            tg = ($urandom_range(1) == 0) ? 32'($urandom_range(4095)) : $urandom;
            step(r, st, fl, bt, tg);
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
